spi_mpu_bridge: RTL and testbench

SPI_MPU_BRIDGE -- requirements
Module: spi_mpu_bridge

---
 rtl/spi_mpu_bridge.sv | 260 ++++++++++++++++++++++++++
 tb/tb_spi_mpu_bridge.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mpu_bridge.sv
// SPI (mode 0) slave that turns write/read command frames into MPU bus cycles
// on the graphics core's clock domain, with one-word read prefetch.
module spi_mpu_bridge #(
    parameter int SCK_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        spi_sck,
    input  logic        _spi_ss,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        _mpu_en,
    output logic        _mpu_rd,
    output logic        _mpu_wr,
    output logic [1:0]  _mpu_be,
    output logic [15:0] mpu_addr,
    output logic [15:0] mpu_data_out,
    input  logic [15:0] mpu_data_in
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR_HI, ADDR_LO, DUMMY, DATA, IGNORE
    } frame_state_t;

    typedef enum logic [1:0] {
        BUS_IDLE, BUS_WR, BUS_RD1, BUS_RD2
    } bus_state_t;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    logic [SCK_SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic sck_prev, ss_prev;
    logic sck_s, ss_s, mosi_s;
    logic sck_rise, sck_fall, ss_rise, ss_fall;

    frame_state_t state, state_next;
    bus_state_t   bus_state;

    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sr;
    logic [7:0]  rx_byte;
    logic        byte_done;
    logic        is_read;
    logic        half;
    logic [7:0]  data_hi;
    logic [15:0] tx_sr;
    logic [15:0] prefetch;
    logic [15:0] wr_word;
    logic        wr_pend, rd_pend;
    logic        en_n, rd_n, wr_n;

    logic addr_hi_load, addr_lo_load, rd_issue, wr_issue, word_start;

    // The ss chain clears to 0 so a select held low across reset release
    // never looks like a falling edge; a frame needs a fresh high->low.
    // NOTE: sequential state uses non-blocking assignments with an async reset term.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            sck_sync  <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            ss_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SCK_SYNC_STAGES-2:0], spi_sck};
            ss_sync   <= {ss_sync[SCK_SYNC_STAGES-2:0], _spi_ss};
            mosi_sync <= {mosi_sync[SCK_SYNC_STAGES-2:0], spi_mosi};
            sck_prev  <= sck_s;
            ss_prev   <= ss_s;
        end
    end

    assign sck_s     = sck_sync[SCK_SYNC_STAGES-1];
    assign ss_s      = ss_sync[SCK_SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SCK_SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev;
    assign sck_fall  = ~sck_s & sck_prev;
    assign ss_rise   = ss_s & ~ss_prev;
    assign ss_fall   = ~ss_s & ss_prev;
    assign rx_byte   = {rx_sr, mosi_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != IDLE);

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: every always_comb output gets a default first, so no latches are inferred.
    always_comb begin
        state_next   = state;
        addr_hi_load = 1'b0;
        addr_lo_load = 1'b0;
        rd_issue     = 1'b0;
        wr_issue     = 1'b0;
        word_start   = 1'b0;
        if (ss_rise) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (ss_fall) state_next = CMD;
                CMD: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) state_next = ADDR_HI;
                        else                                            state_next = IGNORE;
                    end
                end
                ADDR_HI: begin
                    if (byte_done) begin
                        addr_hi_load = 1'b1;
                        state_next   = ADDR_LO;
                    end
                end
                ADDR_LO: begin
                    if (byte_done) begin
                        addr_lo_load = 1'b1;
                        if (is_read) begin
                            rd_issue   = 1'b1;
                            state_next = DUMMY;
                        end else begin
                            state_next = DATA;
                        end
                    end
                end
                DUMMY:   if (byte_done) state_next = DATA;
                DATA: begin
                    // A read word starts on the rising edge that samples its first bit,
                    // so a frame that stops on a word boundary launches no extra read.
                    if (is_read) begin
                        if (sck_rise && bit_cnt == 3'd0 && !half) begin
                            word_start = 1'b1;
                            rd_issue   = 1'b1;
                        end
                    end else if (byte_done && half) begin
                        wr_issue = 1'b1;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            bit_cnt  <= 3'd0;
            rx_sr    <= 7'd0;
            is_read  <= 1'b0;
            half     <= 1'b0;
            data_hi  <= 8'd0;
            tx_sr    <= 16'd0;
            spi_miso <= 1'b0;
        end else begin
            if (ss_fall) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise && state != IDLE) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sr   <= {rx_sr[5:0], mosi_s};
            end

            if (state == CMD && byte_done) is_read <= (rx_byte == CMD_READ);

            if (state == IDLE) begin
                half <= 1'b0;
            end else if (state == DATA && byte_done) begin
                half <= ~half;
                if (!half) data_hi <= rx_byte;
            end

            // The first bit of each read word comes straight from prefetch on the
            // preceding falling edge; the rest shift out of tx_sr.
            if (state == IDLE) begin
                spi_miso <= 1'b0;
            end else if (word_start) begin
                tx_sr <= {prefetch[14:0], 1'b0};
            end else if (sck_fall) begin
                if (state == DATA && is_read) begin
                    if (bit_cnt == 3'd0 && !half) begin
                        spi_miso <= prefetch[15];
                    end else begin
                        spi_miso <= tx_sr[15];
                        tx_sr    <= {tx_sr[14:0], 1'b0};
                    end
                end else begin
                    spi_miso <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            mpu_addr <= 16'd0;
        end else if (addr_hi_load) begin
            mpu_addr[15:8] <= rx_byte;
        end else if (addr_lo_load) begin
            mpu_addr[7:0] <= rx_byte;
        end else if (word_start || bus_state == BUS_WR) begin
            mpu_addr <= mpu_addr + 16'd1;
        end
    end

    // Requests are queued as pending flags so a new frame's first cycle simply
    // waits while a cycle from the previous frame finishes.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            bus_state    <= BUS_IDLE;
            en_n         <= 1'b1;
            rd_n         <= 1'b1;
            wr_n         <= 1'b1;
            mpu_data_out <= 16'd0;
            prefetch     <= 16'd0;
            wr_word      <= 16'd0;
            wr_pend      <= 1'b0;
            rd_pend      <= 1'b0;
        end else begin
            case (bus_state)
                BUS_IDLE: begin
                    if (wr_pend) begin
                        bus_state    <= BUS_WR;
                        en_n         <= 1'b0;
                        wr_n         <= 1'b0;
                        mpu_data_out <= wr_word;
                        wr_pend      <= 1'b0;
                    end else if (rd_pend) begin
                        bus_state <= BUS_RD1;
                        en_n      <= 1'b0;
                        rd_n      <= 1'b0;
                        rd_pend   <= 1'b0;
                    end
                end
                BUS_WR: begin
                    bus_state <= BUS_IDLE;
                    en_n      <= 1'b1;
                    wr_n      <= 1'b1;
                end
                BUS_RD1: bus_state <= BUS_RD2;
                BUS_RD2: begin
                    prefetch  <= mpu_data_in;
                    bus_state <= BUS_IDLE;
                    en_n      <= 1'b1;
                    rd_n      <= 1'b1;
                end
                default: bus_state <= BUS_IDLE;
            endcase
            if (wr_issue) begin
                wr_pend <= 1'b1;
                wr_word <= {data_hi, rx_byte};
            end
            if (rd_issue) rd_pend <= 1'b1;
        end
    end

    assign _mpu_en     = en_n;
    assign _mpu_rd     = rd_n;
    assign _mpu_wr     = wr_n;
    assign _mpu_be     = {en_n, en_n};
    assign spi_miso_oe = ~ss_s & (state != IDLE);

endmodule

// File: tb/tb_spi_mpu_bridge.sv
// Bench for spi_mpu_bridge: SPI master tasks, a memory model on the MPU port,
// and scoreboards for expected bus cycles and MISO bytes.
module tb_spi_mpu_bridge;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        _reset;
    logic        spi_sck, _spi_ss, spi_mosi;
    logic        spi_miso, spi_miso_oe;
    logic        _mpu_en, _mpu_rd, _mpu_wr;
    logic [1:0]  _mpu_be;
    logic [15:0] mpu_addr, mpu_data_out, mpu_data_in;

    always #5 clk = ~clk;

    spi_mpu_bridge #(.SCK_SYNC_STAGES(2)) dut (
        .clk(clk), ._reset(_reset),
        .spi_sck(spi_sck), ._spi_ss(_spi_ss), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        ._mpu_en(_mpu_en), ._mpu_rd(_mpu_rd), ._mpu_wr(_mpu_wr), ._mpu_be(_mpu_be),
        .mpu_addr(mpu_addr), .mpu_data_out(mpu_data_out), .mpu_data_in(mpu_data_in)
    );

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } bus_op_t;

    bus_op_t    bus_q[$];
    logic [7:0] miso_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_model(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hBEEF;
            16'h0011: return 16'h1234;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    always_comb mpu_data_in = mem_model(mpu_addr);

    // Bus monitor: each cycle start is matched against the next expected op.
    int      cyc_len = 0;
    bit      cur_valid = 0;
    bus_op_t cur;

    always @(negedge clk) begin
        if (!_reset) begin
            cyc_len   = 0;
            cur_valid = 0;
        end else if (!_mpu_en) begin
            check("rd_wr_exclusive", {31'd0, _mpu_rd | _mpu_wr}, 32'd1);
            if (cyc_len == 0) begin
                check("expected_cycle_pending", {31'd0, bus_q.size() != 0}, 32'd1);
                if (bus_q.size() != 0) begin
                    cur       = bus_q.pop_front();
                    cur_valid = 1;
                    check("cyc_wr_n", {31'd0, _mpu_wr}, {31'd0, !cur.wr});
                    check("cyc_rd_n", {31'd0, _mpu_rd}, {31'd0, cur.wr});
                    check("cyc_addr", {16'd0, mpu_addr}, {16'd0, cur.addr});
                    check("cyc_be", {30'd0, _mpu_be}, 32'd0);
                    if (cur.wr) check("cyc_wdata", {16'd0, mpu_data_out}, {16'd0, cur.data});
                end else begin
                    cur_valid = 0;
                end
            end
            cyc_len++;
        end else if (cyc_len != 0) begin
            if (cur_valid) check("cyc_len", cyc_len, cur.wr ? 32'd1 : 32'd2);
            check("idle_be", {30'd0, _mpu_be}, 32'd3);
            cyc_len   = 0;
            cur_valid = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_op(input logic wr, input logic [15:0] addr, input logic [15:0] data);
        bus_op_t op;
        op.wr   = wr;
        op.addr = addr;
        op.data = data;
        bus_q.push_back(op);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        tick(HALF);
        spi_sck = 1'b1;
        r = spi_miso;
        tick(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input bit chk, input logic [7:0] exp);
        logic [7:0] rx;
        logic [7:0] want;
        if (chk) miso_q.push_back(exp);
        for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
        if (chk) begin
            want = miso_q.pop_front();
            check("miso_byte", {24'd0, rx}, {24'd0, want});
        end
    endtask

    task automatic frame_begin();
        _spi_ss = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_end();
        tick(HALF);
        _spi_ss = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && bus_q.size() != 0; i++) @(negedge clk);
        check(tag, bus_q.size(), 32'd0);
        tick(6);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, {31'd0, _mpu_en}, 32'd1);
        check({tag, "_rd"}, {31'd0, _mpu_rd}, 32'd1);
        check({tag, "_wr"}, {31'd0, _mpu_wr}, 32'd1);
        check({tag, "_be"}, {30'd0, _mpu_be}, 32'd3);
        check({tag, "_addr"}, {16'd0, mpu_addr}, 32'd0);
        check({tag, "_dout"}, {16'd0, mpu_data_out}, 32'd0);
        check({tag, "_miso"}, {31'd0, spi_miso}, 32'd0);
        check({tag, "_oe"}, {31'd0, spi_miso_oe}, 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        logic r;
        _reset   = 1'b0;
        _spi_ss  = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        tick(4);
        check_reset_outputs("reset");
        _reset = 1'b1;
        tick(20);

        // Write burst: two words, address auto-increment.
        push_op(1'b1, 16'h1234, 16'hABCD);
        push_op(1'b1, 16'h1235, 16'h5678);
        frame_begin();
        check("oe_in_frame", {31'd0, spi_miso_oe}, 32'd1);
        spi_xfer(8'h02, 1, 8'h00);
        spi_xfer(8'h12, 1, 8'h00);
        spi_xfer(8'h34, 1, 8'h00);
        spi_xfer(8'hAB, 0, 8'h00);
        spi_xfer(8'hCD, 0, 8'h00);
        spi_xfer(8'h56, 0, 8'h00);
        spi_xfer(8'h78, 0, 8'h00);
        frame_end();
        drain("write_drain");
        check("oe_after_frame", {31'd0, spi_miso_oe}, 32'd0);
        check("write_addr_after", {16'd0, mpu_addr}, 32'h1236);
        check("dout_hold", {16'd0, mpu_data_out}, 32'h5678);

        // Read burst with prefetch.
        push_op(1'b0, 16'h0010, 16'h0000);
        push_op(1'b0, 16'h0011, 16'h0000);
        push_op(1'b0, 16'h0012, 16'h0000);
        frame_begin();
        spi_xfer(8'h03, 1, 8'h00);
        spi_xfer(8'h00, 1, 8'h00);
        spi_xfer(8'h10, 1, 8'h00);
        spi_xfer(8'hC3, 1, 8'h00);
        spi_xfer(8'h00, 1, 8'hBE);
        spi_xfer(8'h00, 1, 8'hEF);
        spi_xfer(8'h00, 1, 8'h12);
        spi_xfer(8'h00, 1, 8'h34);
        frame_end();
        drain("read_drain");
        check("read_addr_after", {16'd0, mpu_addr}, 32'h0012);

        // Address wrap.
        push_op(1'b1, 16'hFFFF, 16'h1111);
        push_op(1'b1, 16'h0000, 16'h2222);
        frame_begin();
        spi_xfer(8'h02, 0, 8'h00);
        spi_xfer(8'hFF, 0, 8'h00);
        spi_xfer(8'hFF, 0, 8'h00);
        spi_xfer(8'h11, 0, 8'h00);
        spi_xfer(8'h11, 0, 8'h00);
        spi_xfer(8'h22, 0, 8'h00);
        spi_xfer(8'h22, 0, 8'h00);
        frame_end();
        drain("wrap_drain");
        check("wrap_addr_after", {16'd0, mpu_addr}, 32'h0001);

        // Abort on a half word, then a normal frame.
        frame_begin();
        spi_xfer(8'h02, 0, 8'h00);
        spi_xfer(8'h00, 0, 8'h00);
        spi_xfer(8'h20, 0, 8'h00);
        spi_xfer(8'hAB, 0, 8'h00);
        frame_end();
        tick(40);
        check("abort_oe", {31'd0, spi_miso_oe}, 32'd0);
        push_op(1'b1, 16'h0030, 16'hCAFE);
        frame_begin();
        spi_xfer(8'h02, 0, 8'h00);
        spi_xfer(8'h00, 0, 8'h00);
        spi_xfer(8'h30, 0, 8'h00);
        spi_xfer(8'hCA, 0, 8'h00);
        spi_xfer(8'hFE, 0, 8'h00);
        frame_end();
        drain("after_abort_drain");

        // Unknown command: no cycles, MISO stays low.
        frame_begin();
        spi_xfer(8'h55, 1, 8'h00);
        spi_xfer(8'hA5, 1, 8'h00);
        spi_xfer(8'h5A, 1, 8'h00);
        spi_xfer(8'hFF, 1, 8'h00);
        spi_xfer(8'h03, 1, 8'h00);
        frame_end();
        tick(40);
        check("badcmd_addr", {16'd0, mpu_addr}, 32'h0031);

        // Asynchronous reset in the middle of a read burst.
        push_op(1'b0, 16'h0040, 16'h0000);
        push_op(1'b0, 16'h0041, 16'h0000);
        frame_begin();
        spi_xfer(8'h03, 1, 8'h00);
        spi_xfer(8'h00, 1, 8'h00);
        spi_xfer(8'h40, 1, 8'h00);
        spi_xfer(8'h00, 1, 8'h00);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
        check("midread_oe", {31'd0, spi_miso_oe}, 32'd1);
        #3;
        _reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        check("midread_queue", bus_q.size(), 32'd0);
        tick(2);
        _spi_ss = 1'b1;
        tick(5);
        _reset = 1'b1;
        tick(40);
        check("post_release_addr", {16'd0, mpu_addr}, 32'd0);

        // Recovery frame after reset.
        push_op(1'b1, 16'h0050, 16'h1234);
        frame_begin();
        spi_xfer(8'h02, 1, 8'h00);
        spi_xfer(8'h00, 1, 8'h00);
        spi_xfer(8'h50, 1, 8'h00);
        spi_xfer(8'h12, 0, 8'h00);
        spi_xfer(8'h34, 0, 8'h00);
        frame_end();
        drain("recovery_drain");
        check("recovery_addr_after", {16'd0, mpu_addr}, 32'h0051);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
